// File: rtl/alu_result_stage_if.sv
// Handshake and data bus between the ALU, the result stage and the
// register-file write port.
interface alu_result_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] alu_out;
    logic [7:0] alu_b;
    logic       alu_carry;
    logic       alu_half_carry;
    logic       alu_overflow;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;

    // ALU / consumer side
    modport master (
        output in_valid, op, alu_out, alu_b, alu_carry, alu_half_carry,
               alu_overflow, out_ready,
        input  in_ready, out_valid, result
    );

    // Result stage side
    modport slave (
        input  in_valid, op, alu_out, alu_b, alu_carry, alu_half_carry,
               alu_overflow, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu_result_stage.sv
// 6502 ALU result stage: registers the binary ALU result, applies BCD
// correction to ADC/SBC in decimal mode over two extra cycles, owns the
// status register P and hands the result on over valid/ready.
module alu_result_stage #(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_result_stage_if.slave   bus,
    input  logic                p_load,
    input  logic [7:0]          p_load_val,
    input  logic                flag_strobe,
    input  logic [2:0]          flag_op,
    output logic [7:0]          p_out
);
    localparam logic [2:0] OP_PASS  = 3'd0;
    localparam logic [2:0] OP_ADC   = 3'd1;
    localparam logic [2:0] OP_SBC   = 3'd2;
    localparam logic [2:0] OP_CMP   = 3'd4;
    localparam logic [2:0] OP_SHIFT = 3'd5;
    localparam logic [2:0] OP_BIT   = 3'd6;

    // P bit positions: N V 1 0 D I Z C
    localparam int P_N = 7, P_V = 6, P_D = 3, P_I = 2, P_Z = 1, P_C = 0;

    typedef enum logic [1:0] {IDLE, ADJ_LO, ADJ_HI, HOLD} state_t;

    state_t     state;
    logic [7:0] r;
    logic [2:0] op_q;
    logic       c_q, h_q, v_q, cacc;
    logic       out_valid_q;
    logic [7:0] result_q;
    logic [7:0] p_q;

    logic       accept;
    logic       decimal_entry;
    logic       commit;
    logic [8:0] lo_sum;
    logic [7:0] hi_r;
    logic       hi_c;
    logic [2:0] cm_op;
    logic [7:0] cm_res;
    logic       cm_c;
    logic       cm_v;
    logic [7:0] p_next;

    assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign p_out         = p_q;

    assign accept        = bus.in_valid && bus.in_ready;
    // Decimal entry looks at P.D as held, before any same-edge P update.
    assign decimal_entry = accept && p_q[P_D] &&
                           ((bus.op == OP_ADC) || (bus.op == OP_SBC));
    assign commit        = (accept && !decimal_entry) || (state == ADJ_HI);
    assign lo_sum        = {1'b0, r} + 9'h006;

    // High-nibble BCD correction and the decimal carry it produces.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        hi_r = r;
        hi_c = c_q;
        if (op_q == OP_ADC) begin
            if (cacc || (r[7:4] > 4'd9)) begin
                hi_r = r + 8'h60;
                hi_c = 1'b1;
            end else begin
                hi_c = cacc;
            end
        end else if (!c_q) begin
            hi_r = r - 8'h60;
        end
    end

    // Select the commit source: live ALU inputs, or the corrected value.
    always_comb begin
        cm_op  = bus.op;
        cm_res = bus.alu_out;
        cm_c   = bus.alu_carry;
        cm_v   = bus.alu_overflow;
        if (state == ADJ_HI) begin
            cm_op  = op_q;
            cm_res = hi_r;
            cm_c   = hi_c;
            cm_v   = v_q;
        end
    end

    // Next P: ALU flags, then explicit flag op, then p_load on top.
    always_comb begin
        p_next = p_q;
        if (commit) begin
            p_next[P_N] = cm_res[7];
            p_next[P_Z] = (cm_res == 8'h00);
            case (cm_op)
                OP_ADC, OP_SBC: begin
                    p_next[P_C] = cm_c;
                    p_next[P_V] = cm_v;
                end
                OP_CMP, OP_SHIFT: p_next[P_C] = cm_c;
                OP_BIT: begin
                    p_next[P_N] = bus.alu_b[7];
                    p_next[P_V] = bus.alu_b[6];
                end
                default: ;  // PASS, LOGIC and reserved: N/Z only
            endcase
        end
        if (flag_strobe) begin
            case (flag_op)
                3'd0:    p_next[P_C] = 1'b0;
                3'd1:    p_next[P_C] = 1'b1;
                3'd2:    p_next[P_I] = 1'b0;
                3'd3:    p_next[P_I] = 1'b1;
                3'd4:    p_next[P_D] = 1'b0;
                3'd5:    p_next[P_D] = 1'b1;
                3'd6:    p_next[P_V] = 1'b0;
                default: ;
            endcase
        end
        if (p_load) p_next = p_load_val;
        p_next[5] = 1'b1;
        p_next[4] = 1'b0;
    end

    // Stage FSM, result register and P register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= 8'h00;
            op_q        <= OP_PASS;
            c_q         <= 1'b0;
            h_q         <= 1'b0;
            v_q         <= 1'b0;
            cacc        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= 8'h00;
            p_q         <= RESET_P;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            p_q <= p_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        r    <= bus.alu_out;
                        op_q <= bus.op;
                        c_q  <= bus.alu_carry;
                        h_q  <= bus.alu_half_carry;
                        v_q  <= bus.alu_overflow;
                        if (decimal_entry) begin
                            out_valid_q <= 1'b0;
                            state       <= ADJ_LO;
                        end else begin
                            result_q    <= bus.alu_out;
                            out_valid_q <= 1'b1;
                        end
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end else if (out_valid_q) begin
                        state <= HOLD;
                    end
                end
                ADJ_LO: begin
                    if (op_q == OP_ADC) begin
                        if (h_q || (r[3:0] > 4'd9)) begin
                            r    <= lo_sum[7:0];
                            cacc <= c_q | lo_sum[8];
                        end else begin
                            cacc <= c_q;
                        end
                    end else if (!h_q) begin
                        r <= r - 8'h06;
                    end
                    state <= ADJ_HI;
                end
                ADJ_HI: begin
                    r           <= hi_r;
                    result_q    <= hi_r;
                    out_valid_q <= 1'b1;
                    state       <= IDLE;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       p_load = 1'b0;
    logic [7:0] p_load_val = 8'h00;
    logic       flag_strobe = 1'b0;
    logic [2:0] flag_op = 3'd7;
    logic [7:0] p_out;

    int n_vec = 0;
    int n_err = 0;

    alu_result_stage_if bus ();

    alu_result_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .p_load      (p_load),
        .p_load_val  (p_load_val),
        .flag_strobe (flag_strobe),
        .flag_op     (flag_op),
        .p_out       (p_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one ALU op (optionally with a same-edge flag op / P load),
    // measure latency to out_valid, then check result and P.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic c, input logic h, input logic v,
                          input logic sf, input logic [2:0] sfop,
                          input logic pl, input logic [7:0] plv,
                          input int exp_lat, input logic [7:0] exp_res,
                          input logic [7:0] exp_p);
        int n;
        int lat;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        bus.op = o; bus.alu_out = a; bus.alu_b = b;
        bus.alu_carry = c; bus.alu_half_carry = h; bus.alu_overflow = v;
        bus.in_valid = 1'b1;
        flag_strobe = sf; flag_op = sfop;
        p_load = pl; p_load_val = plv;
        tick();
        bus.in_valid = 1'b0;
        flag_strobe = 1'b0;
        p_load = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 8'(lat), 8'(exp_lat));
        check({tag, "_res"}, bus.result, exp_res);
        check({tag, "_p"}, p_out, exp_p);
    endtask

    task automatic do_flag(input string tag, input logic [2:0] fop, input logic [7:0] exp_p);
        flag_strobe = 1'b1;
        flag_op = fop;
        tick();
        flag_strobe = 1'b0;
        check(tag, p_out, exp_p);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = 3'd0; bus.alu_out = 8'h00; bus.alu_b = 8'h00;
        bus.alu_carry = 1'b0; bus.alu_half_carry = 1'b0; bus.alu_overflow = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_p", p_out, 8'h24);
        check("rst_ov", 8'(bus.out_valid), 8'h00);
        check("rst_res", bus.result, 8'h00);
        rst_n = 1'b1;
        tick();
        check("rst_rdy", 8'(bus.in_ready), 8'h01);

        // Binary ADC with overflow
        run_op("adc_bin", 3'd1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 8'h00, 1, 8'h80, 8'hE4);
        do_flag("sed", 3'd5, 8'hEC);
        // Decimal ADC: 19+28 and 58+46+1
        run_op("adc_d1", 3'd1, 8'h41, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 3, 8'h47, 8'h2C);
        run_op("adc_d2", 3'd1, 8'h9F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 3, 8'h05, 8'h2D);
        // Decimal SBC: 42-15 and a borrowing case
        run_op("sbc_d1", 3'd2, 8'h2D, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 3, 8'h27, 8'h2D);
        run_op("sbc_d2", 3'd2, 8'hF9, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 3, 8'h99, 8'hAC);
        do_flag("cld", 3'd4, 8'hA4);

        // Back-pressure: result held, no new accept while stalled
        tick();
        bus.out_ready = 1'b0;
        run_op("hold_op", 3'd0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 1, 8'h5A, 8'h24);
        bus.op = 3'd0; bus.alu_out = 8'h00; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_res", bus.result, 8'h5A);
            check("hold_rdy", 8'(bus.in_ready), 8'h00);
            check("hold_ov", 8'(bus.out_valid), 8'h01);
        end
        bus.out_ready = 1'b1;
        tick();
        check("xfer_ov", 8'(bus.out_valid), 8'h00);
        check("xfer_res", bus.result, 8'h5A);
        tick();
        bus.in_valid = 1'b0;
        check("next_ov", 8'(bus.out_valid), 8'h01);
        check("next_res", bus.result, 8'h00);
        check("next_p", p_out, 8'h26);

        // Same-edge priority
        run_op("clc_merge", 3'd1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1, 8'h10, 8'h24);
        run_op("pload_win", 3'd1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 8'hFF, 1, 8'h10, 8'hEF);
        p_load = 1'b1; p_load_val = 8'h00;
        tick();
        p_load = 1'b0;
        check("pload_00", p_out, 8'h20);

        // Remaining operation classes
        run_op("bit", 3'd6, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 1, 8'h00, 8'hE2);
        run_op("cmp", 3'd4, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 1, 8'h00, 8'h63);
        run_op("shift", 3'd5, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 1, 8'h80, 8'hE0);
        run_op("logic", 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 8'h00, 1, 8'h00, 8'h62);
        run_op("rsvd", 3'd7, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 1, 8'h01, 8'h60);

        // Reset during ADJ_HI aborts the decimal op
        do_flag("sed2", 3'd5, 8'h68);
        bus.op = 3'd1; bus.alu_out = 8'h41; bus.alu_half_carry = 1'b1;
        bus.alu_carry = 1'b0; bus.alu_overflow = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("adj_ov", 8'(bus.out_valid), 8'h00);
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_p", p_out, 8'h24);
        check("abort_ov", 8'(bus.out_valid), 8'h00);
        check("abort_res", bus.result, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_rdy", 8'(bus.in_ready), 8'h01);
        check("abort_ov2", 8'(bus.out_valid), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
